// File: rtl/canny_accel_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 16x7 unsigned multiplier between NREQ requesters.
// Each in-flight product carries a requester tag; an unaccepted result freezes the whole pipe.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// Operand side: req_ready is combinational and one-hot; the requester holds req_valid and
// its operands until that edge. Result side: res_valid[i] stays high with res_data stable
// until res_ready[i]; while it waits, the pipe and the arbiter are frozen.
module canny_accel_mul_arbiter #(
  parameter int NREQ = 3,
  parameter int LAT  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [7*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      res_valid,
  input  logic [NREQ-1:0]      res_ready,
  output logic [22:0]          res_data,
  output logic                 busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LAT-1:0] r_tag_v;
  logic [IDW-1:0] r_tag_id [LAT];
  logic [IDW-1:0] r_last_gnt;
  logic [15:0]    r_mul_a;
  logic [6:0]     r_mul_b;
  logic [22:0]    r_mul_p [LAT-1];

  logic           w_stall;
  logic           w_ce;
  logic           w_found;
  logic           w_issue;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_gnt_id;
  logic [15:0]    w_din_a;
  logic [6:0]     w_din_b;

  // Rotating search starting one past the last granted requester.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = r_last_gnt;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  always_comb begin
    w_din_a = '0;
    w_din_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        w_din_a = req_a[16*i +: 16];
        w_din_b = req_b[7*i +: 7];
      end
    end
  end

  always_comb begin
    res_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      res_valid[i] = r_tag_v[LAT-1] && (r_tag_id[LAT-1] == IDW'(i));
    end
  end

  assign w_stall = |(res_valid & ~res_ready);
  assign w_ce    = ~w_stall;
  // Gated by reset so no requester sees an acceptance that the reset edge would discard.
  assign w_issue = w_found & w_ce & ~reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_issue && (w_gnt_id == IDW'(i));
    end
  end

  assign busy     = |r_tag_v;
  assign res_data = r_mul_p[LAT-2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v    <= '0;
      r_last_gnt <= IDW'(NREQ - 1);
      for (int i = 0; i < LAT; i++) begin
        r_tag_id[i] <= '0;
      end
    end else if (w_ce) begin
      r_tag_v     <= {r_tag_v[LAT-2:0], w_issue};
      r_tag_id[0] <= w_gnt_id;
      for (int i = 1; i < LAT; i++) begin
        r_tag_id[i] <= r_tag_id[i-1];
      end
      if (w_issue) begin
        r_last_gnt <= w_gnt_id;
      end
    end
  end

  // Multiplier datapath: operand stage then LAT-1 product stages, all on the shared enable.
  always_ff @(posedge clk) begin
    if (w_ce) begin
      r_mul_a    <= w_din_a;
      r_mul_b    <= w_din_b;
      r_mul_p[0] <= 23'(r_mul_a) * 23'(r_mul_b);
      for (int i = 1; i < LAT - 1; i++) begin
        r_mul_p[i] <= r_mul_p[i-1];
      end
    end
  end
endmodule

// File: tb/tb_canny_accel_mul_arbiter.sv
// Scoreboard bench for canny_accel_mul_arbiter: a queue-based reference model predicts grants,
// result timing under back-pressure and products; directed scenarios followed by random traffic.
module tb_canny_accel_mul_arbiter;
  localparam int NREQ = 3;
  localparam int LAT  = 3;
  localparam int IDW  = 2;
  localparam int W    = IDW + 23;
  localparam int AW   = 16 * NREQ;
  localparam int BW   = 7 * NREQ;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [AW-1:0]   req_a = '0;
  logic [BW-1:0]   req_b = '0;
  logic [NREQ-1:0] res_valid;
  logic [NREQ-1:0] res_ready = '0;
  logic [22:0]     res_data;
  logic            busy;

  canny_accel_mul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int              total = 0;
  int              bad = 0;
  logic [W-1:0]    exp_q[$];   // {requester id, product}, in issue order
  int              due_q[$];   // unstalled cycles left before the entry reaches the output
  logic            stall_m = 1'b0;
  int              m_last = NREQ - 1;
  logic [NREQ-1:0] hs = '0;
  logic            prev_rst = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: runs mid-cycle, decides whether the model is stalled and pops on acceptance.
  always @(negedge clk) begin
    logic            present;
    logic [NREQ-1:0] exp_rv;
    logic [W-1:0]    head;
    logic [IDW-1:0]  hid;
    present = 1'b0;
    exp_rv  = '0;
    head    = '0;
    hid     = '0;
    if (reset) begin
      if (prev_rst) begin
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
      end
      exp_q.delete();
      due_q.delete();
      stall_m = 1'b0;
    end else begin
      if (due_q.size() > 0 && due_q[0] == 0) begin
        present     = 1'b1;
        head        = exp_q[0];
        hid         = head[W-1:23];
        exp_rv[hid] = 1'b1;
      end
      check("busy", 32'(busy), 32'(due_q.size() != 0));
      check("res_valid", 32'(res_valid), 32'(exp_rv));
      if (present) check("res_data", 32'(res_data), 32'(head[22:0]));
      stall_m = present && !res_ready[hid];
      if (!stall_m) begin
        if (present) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        foreach (due_q[j]) due_q[j] = due_q[j] - 1;
      end
    end
    prev_rst = reset;
  end

  // Issue side: predicts the round-robin grant and pushes the expected product.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rr;
    int              gid;
    int              idx;
    logic [15:0]     a;
    logic [6:0]      b;
    #1;
    exp_rr = '0;
    gid    = -1;
    if (reset) begin
      m_last = NREQ - 1;
      hs     = '0;
    end else begin
      if (!stall_m) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (gid < 0 && req_valid[idx[IDW-1:0]]) gid = idx;
        end
      end
      if (gid >= 0) exp_rr[gid[IDW-1:0]] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rr));
      hs = req_valid & req_ready;
      if (gid >= 0) begin
        a = 16'(req_a >> (16 * gid));
        b = 7'(req_b >> (7 * gid));
        exp_q.push_back({gid[IDW-1:0], 23'(a) * 23'(b)});
        due_q.push_back(LAT - 1);
        m_last = gid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs;
  endtask

  function automatic logic pending(input int i);
    return req_valid[i[IDW-1:0]];
  endfunction

  task automatic set_req(input int i, input logic [15:0] a, input logic [6:0] b);
    req_valid = req_valid | (NREQ'(1) << i);
    req_a     = (req_a & ~(AW'(16'hFFFF) << (16 * i))) | (AW'(a) << (16 * i));
    req_b     = (req_b & ~(BW'(7'h7F) << (7 * i))) | (BW'(b) << (7 * i));
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    req_valid = '0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    res_ready = '1;
    while ((exp_q.size() != 0 || req_valid != '0) && n < 60) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && req_valid == '0), 32'(1));
  endtask

  function automatic logic [15:0] rand_a();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 16'd0;
    if (sel == 1) return 16'hFFFF;
    return 16'($urandom_range(0, 65535));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);
    res_ready = '1;

    // single request
    set_req(0, 16'd1000, 7'd5);
    repeat (6) tick();
    drain();

    // fairness: every requester continuously valid
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending(i)) set_req(i, rand_a(), 7'($urandom_range(0, 127)));
      end
      tick();
    end
    drain();

    // back-pressure on requester 1 with others waiting
    set_req(1, 16'd300, 7'd77);
    tick();
    res_ready = 3'b101;
    repeat (3) tick();
    set_req(0, 16'd12345, 7'd99);
    set_req(2, 16'd7, 7'd7);
    repeat (4) tick();
    res_ready = '1;
    drain();

    // operand extremes
    set_req(0, 16'hFFFF, 7'd127);
    set_req(1, 16'd0, 7'd127);
    set_req(2, 16'hFFFF, 7'd0);
    drain();

    // reset with three products in flight, then requester 0 must win first
    set_req(0, 16'd11, 7'd3);
    set_req(1, 16'd22, 7'd4);
    set_req(2, 16'd33, 7'd5);
    repeat (3) tick();
    do_reset(2);
    repeat (3) tick();
    set_req(0, 16'd100, 7'd2);
    set_req(1, 16'd200, 7'd3);
    set_req(2, 16'd300, 7'd4);
    drain();

    // result accepted in the same cycle a new issue happens
    set_req(2, 16'd4242, 7'd100);
    repeat (3) tick();
    set_req(0, 16'd999, 7'd3);
    tick();
    drain();

    // random traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending(i) && $urandom_range(0, 99) < 50) set_req(i, rand_a(), 7'($urandom_range(0, 127)));
      end
      res_ready = NREQ'($urandom) | NREQ'($urandom);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
